// File: rtl/interp_pkg.sv
// Shared types and constants for the interpolation reference-window path.
package interp_pkg;

    localparam int PIX_W    = 8;
    localparam int WIN      = 15;
    localparam int WORD_PIX = 8;

    typedef logic [WIN*PIX_W-1:0] row_t;
    typedef logic [63:0]          word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_RD2,
        ST_CAP,
        ST_OUT,
        ST_FIN
    } state_t;

endpackage

// File: rtl/row_aligner.sv
// Picks WIN pixels starting at an unaligned offset out of three captured words,
// replicating the rightmost frame column for positions past the right edge.
module row_aligner
    import interp_pkg::*;
#(
    parameter int IMG_W = 64
) (
    input  word_t                      w0,
    input  word_t                      w1,
    input  word_t                      w2,
    input  logic [2:0]                 off,
    input  logic [$clog2(IMG_W)-1:0]   x,
    output row_t                       row
);

    localparam int LAST_WORD = IMG_W / WORD_PIX - 1;

    logic [3*64-1:0] assembled;
    int              wx;
    int              idx;

    always_comb begin
        assembled = {w2, w1, w0};
        wx        = int'(x) >> 3;
        idx       = 0;
        row       = '0;
        for (int k = 0; k < WIN; k++) begin
            // Column IMG_W-1 always lives in the slot holding the last frame word.
            if (int'(x) + k > IMG_W - 1) begin
                idx = WORD_PIX * (LAST_WORD - wx) + WORD_PIX - 1;
            end else begin
                idx = int'(off) + k;
            end
            row[k*PIX_W +: PIX_W] = assembled[idx*PIX_W +: PIX_W];
        end
    end

endmodule

// File: rtl/ref_window_fetcher.sv
// Fetches a WINxWIN reference window from word-organised frame memory and
// streams it row by row; handshake: a row transfers on a cycle with row_valid && row_ready.
module ref_window_fetcher
    import interp_pkg::state_t, interp_pkg::word_t, interp_pkg::row_t;
#(
    parameter int PIX_W  = 8,
    parameter int WIN    = 15,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [$clog2(IMG_W)-1:0]   start_x,
    input  logic [$clog2(IMG_H)-1:0]   start_y,
    output logic                       busy,
    output logic                       done,
    output logic                       mem_rd_en,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [63:0]                mem_rd_data,
    output logic [WIN*PIX_W-1:0]       row_out,
    output logic                       row_valid,
    input  logic                       row_ready,
    output logic [3:0]                 row_idx,
    output logic                       row_last,
    output state_t                     dbg_state
);

    import interp_pkg::ST_IDLE;
    import interp_pkg::ST_RD0;
    import interp_pkg::ST_RD1;
    import interp_pkg::ST_RD2;
    import interp_pkg::ST_CAP;
    import interp_pkg::ST_OUT;
    import interp_pkg::ST_FIN;

    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
    localparam int WORDS = IMG_W / 8;

    state_t         state_q, state_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [3:0]     row_idx_q, row_idx_d;
    word_t          slot0_q, slot0_d;
    word_t          slot1_q, slot1_d;
    word_t          slot2_q, slot2_d;
    row_t           aligned;

    int             ry;
    int             wc;
    int             rd_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            row_idx_q <= '0;
            slot0_q   <= '0;
            slot1_q   <= '0;
            slot2_q   <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            row_idx_q <= row_idx_d;
            slot0_q   <= slot0_d;
            slot1_q   <= slot1_d;
            slot2_q   <= slot2_d;
        end
    end

    // Each RDn strobe's data arrives one state later, so capture lags by one.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        row_idx_d = row_idx_q;
        slot0_d   = slot0_q;
        slot1_d   = slot1_q;
        slot2_d   = slot2_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d       = start_x;
                    y_d       = start_y;
                    row_idx_d = '0;
                    state_d   = ST_RD0;
                end
            end
            ST_RD0: state_d = ST_RD1;
            ST_RD1: begin
                slot0_d = mem_rd_data;
                state_d = ST_RD2;
            end
            ST_RD2: begin
                slot1_d = mem_rd_data;
                state_d = ST_CAP;
            end
            ST_CAP: begin
                slot2_d = mem_rd_data;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (row_ready) begin
                    if (row_idx_q == 4'(WIN - 1)) begin
                        state_d = ST_FIN;
                    end else begin
                        row_idx_d = row_idx_q + 4'd1;
                        state_d   = ST_RD0;
                    end
                end
            end
            ST_FIN: begin
                row_idx_d = '0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bottom rows and right words are clamped so reads never leave the frame.
    always_comb begin
        rd_n      = 0;
        mem_rd_en = 1'b0;
        case (state_q)
            ST_RD0: begin mem_rd_en = 1'b1; rd_n = 0; end
            ST_RD1: begin mem_rd_en = 1'b1; rd_n = 1; end
            ST_RD2: begin mem_rd_en = 1'b1; rd_n = 2; end
            default: begin mem_rd_en = 1'b0; rd_n = 0; end
        endcase
        ry = int'(y_q) + int'(row_idx_q);
        if (ry > IMG_H - 1) ry = IMG_H - 1;
        wc = (int'(x_q) >> 3) + rd_n;
        if (wc > WORDS - 1) wc = WORDS - 1;
        mem_addr = mem_rd_en ? ADDR_W'(ry * WORDS + wc) : '0;
    end

    row_aligner #(
        .IMG_W (IMG_W)
    ) u_row_aligner (
        .w0  (slot0_q),
        .w1  (slot1_q),
        .w2  (slot2_q),
        .off (x_q[2:0]),
        .x   (x_q),
        .row (aligned)
    );

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_FIN);
    assign row_valid = (state_q == ST_OUT);
    assign row_out   = row_valid ? aligned : '0;
    assign row_idx   = row_idx_q;
    assign row_last  = row_valid && (row_idx_q == 4'(WIN - 1));
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ref_window_fetcher.sv
// Randomised bench for ref_window_fetcher on a 16x16 frame where pixel(c,r) = r*16+c.
module tb_ref_window_fetcher;

  localparam int IMG_W  = 16;
  localparam int IMG_H  = 16;
  localparam int ADDR_W = 16;
  localparam int EW     = 125;

  logic               clock;
  logic               reset;
  logic               start;
  logic [3:0]         start_x;
  logic [3:0]         start_y;
  logic               busy;
  logic               done;
  logic               mem_rd_en;
  logic [ADDR_W-1:0]  mem_addr;
  logic [63:0]        mem_rd_data;
  logic [119:0]       row_out;
  logic               row_valid;
  logic               row_ready;
  logic [3:0]         row_idx;
  logic               row_last;
  interp_pkg::state_t dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int win_y = 0;
  int ready_mode = 0;
  bit stall_done = 0;

  ref_window_fetcher #(
    .PIX_W (8), .WIN (15), .IMG_W (IMG_W), .IMG_H (IMG_H), .ADDR_W (ADDR_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .start_x     (start_x),
    .start_y     (start_y),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .row_out     (row_out),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .row_idx     (row_idx),
    .row_last    (row_last),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  // reference frame content
  function automatic logic [7:0] pix(int c, int r);
    return 8'(r * 16 + c);
  endfunction

  function automatic logic [63:0] mem_word(logic [ADDR_W-1:0] a);
    logic [63:0] w = '0;
    for (int j = 0; j < 8; j++) w[j*8 +: 8] = pix(int'(a[0]) * 8 + j, int'(a >> 1));
    return w;
  endfunction

  function automatic logic [119:0] ref_row(int x, int y, int i);
    logic [119:0] r = '0;
    int rr = (y + i > IMG_H - 1) ? IMG_H - 1 : y + i;
    for (int k = 0; k < 15; k++) r[k*8 +: 8] = pix((x + k > IMG_W - 1) ? IMG_W - 1 : x + k, rr);
    return r;
  endfunction

  // memory: data one cycle after the strobe, junk otherwise
  always @(posedge clock) begin
    if (mem_rd_en) mem_rd_data <= mem_word(mem_addr);
    else           mem_rd_data <= {$urandom, $urandom};
  end

  // consumer ready
  initial begin
    row_ready = 1;
    forever begin
      @(posedge clock); #1;
      case (ready_mode)
        0:       row_ready = 1;
        1:       row_ready = ($urandom_range(0, 3) != 0);
        default: row_ready = (hs_cnt != 3) || stall_done;
      endcase
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (mem_rd_en) begin
      check("rd_row_no_out", {row_valid, 16'(mem_addr >> 1)},
            {1'b0, 16'((win_y + hs_cnt > IMG_H - 1) ? IMG_H - 1 : win_y + hs_cnt)});
    end
    if (row_valid && row_ready) begin
      if (exp_q.size() == 0) begin
        check("rows_expected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("row_out", row_out, e[124:5]);
        check("row_idx_last", {row_idx, row_last}, e[4:0]);
      end
      hs_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      hs_cnt = 0;
    end
    if (reset) hs_cnt = 0;
  end

  // driver tasks
  task automatic push_window(input int x, input int y);
    win_y = y;
    done_cnt = 0;
    for (int i = 0; i < 15; i++) exp_q.push_back({ref_row(x, y, i), 4'(i), i == 14});
  endtask

  task automatic pulse_start(input int x, input int y, output int c0);
    @(negedge clock);
    start_x = 4'(x);
    start_y = 4'(y);
    start = 1;
    @(posedge clock); #1;
    c0 = cyc;
    start = 0;
  endtask

  task automatic wait_done(input int c0, input bit chk_lat);
    bit got = 0;
    for (int t = 0; t < 3000 && !got; t++) begin
      @(negedge clock);
      if (done_cnt > 0) got = 1;
    end
    check("done_seen", got, 1);
    if (got && chk_lat) check("done_latency", done_cyc - c0, 75);
    @(negedge clock);
    check("idle_after_done", {busy, done}, 2'b00);
    check("rows_left", exp_q.size(), 0);
  endtask

  task automatic run_window(input int x, input int y, input bit chk_lat);
    int c0;
    push_window(x, y);
    pulse_start(x, y, c0);
    wait_done(c0, chk_lat);
  endtask

  initial begin
    int c0;
    bit found;
    bit stable_ok;
    logic [119:0] held;
    reset = 1; start = 0; start_x = 0; start_y = 0;
    repeat (3) @(negedge clock);
    check("rst_ctrl", {busy, done, mem_rd_en, row_valid, row_last}, 5'b0);
    check("rst_addr", mem_addr, 0);
    check("rst_row", row_out, 0);
    check("rst_idx", row_idx, 0);
    reset = 0;
    @(negedge clock);

    // directed windows: aligned, unaligned, right edge, bottom edge
    run_window(0, 0, 1);
    run_window(5, 2, 1);
    run_window(8, 0, 1);
    run_window(0, 10, 1);
    run_window(15, 15, 1);

    // backpressure on row 3 with an ignored start
    ready_mode = 2;
    stall_done = 0;
    push_window(3, 1);
    pulse_start(3, 1, c0);
    found = 0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clock);
      if (row_valid && hs_cnt == 3) found = 1;
    end
    check("stall_reached", found, 1);
    held = row_out;
    stable_ok = 1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin start_x = 4'd7; start_y = 4'd7; start = 1; end
      if (i == 6) start = 0;
      if (row_out !== held || row_idx !== 4'd3 || mem_rd_en || !row_valid) stable_ok = 0;
      @(negedge clock);
    end
    check("stall_stable", stable_ok, 1);
    stall_done = 1;
    wait_done(c0, 0);
    ready_mode = 0;

    // reset during RD1 of row 6
    push_window(0, 0);
    pulse_start(0, 0, c0);
    found = 0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clock);
      if (dbg_state == interp_pkg::ST_RD1 && hs_cnt == 6) found = 1;
    end
    check("rd1_row6_reached", found, 1);
    reset = 1;
    exp_q.delete();
    done_cnt = 0;
    @(negedge clock);
    check("mid_reset_idle", {busy, row_valid, done}, 3'b000);
    reset = 0;
    repeat (10) @(negedge clock);
    check("no_done_after_reset", done_cnt, 0);
    run_window(0, 0, 1);

    // random windows with random backpressure
    ready_mode = 1;
    for (int n = 0; n < 8; n++) run_window($urandom_range(0, 15), $urandom_range(0, 15), 0);
    ready_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
